// File: rtl/clk_div_bank_if.sv
// rtl/clk_div_bank_if.sv - control and status bundle for clk_div_bank
//
// Purpose: groups the per-channel run enables, the shared divider write
// port and the registered per-channel outputs of clk_div_bank.
//
// Signals:
//   en      [CHANNELS] per-channel run enable
//   wr_en              divider write strobe (one write per cycle)
//   wr_ch   [CH_W]     target channel of the write
//   wr_data [CNT_W]    new divider value N
//   out     [CHANNELS] registered square-wave outputs
//   tick    [CHANNELS] one-cycle pulse, high while a new out level is fresh
//   pending [CHANNELS] a written value is waiting for the terminal count
//
// Modports: master drives enables and writes; slave is the divider bank.

interface clk_div_bank_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int CH_W     = 2
);
    logic [CHANNELS-1:0] en;
    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic [CNT_W-1:0]    wr_data;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] pending;

    modport master (
        output en,
        output wr_en,
        output wr_ch,
        output wr_data,
        input  out,
        input  tick,
        input  pending
    );

    modport slave (
        input  en,
        input  wr_en,
        input  wr_ch,
        input  wr_data,
        output out,
        output tick,
        output pending
    );
endinterface

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of programmable square-wave / strobe dividers
//
// Purpose: CHANNELS independent dividers in the clk domain. Each running
// channel toggles its output every N+1 enabled cycles (period 2*(N+1)).
// Divider values written while a channel runs are parked in a shadow
// register and only become active at that channel's terminal count, so a
// retune never shortens or stretches the half-period in progress.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset, clears every channel to N=0
//   bus    clk_div_bank_if slave modport (en, wr_*, out, tick, pending)

module clk_div_bank #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int CH_W     = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_div_bank_if.slave  bus
);

    // Per-channel state, current (_q) and next (_d).
    logic [CNT_W-1:0]    cnt_q    [CHANNELS];
    logic [CNT_W-1:0]    cnt_d    [CHANNELS];
    logic [CNT_W-1:0]    active_q [CHANNELS];
    logic [CNT_W-1:0]    active_d [CHANNELS];
    logic [CNT_W-1:0]    shadow_q [CHANNELS];
    logic [CNT_W-1:0]    shadow_d [CHANNELS];
    logic [CHANNELS-1:0] pend_q;
    logic [CHANNELS-1:0] pend_d;
    logic [CHANNELS-1:0] out_q;
    logic [CHANNELS-1:0] out_d;
    logic [CHANNELS-1:0] tick_q;
    logic [CHANNELS-1:0] tick_d;

    // Decoded per-channel events for this edge.
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] at_term;

    // A select value at or above CHANNELS matches no channel, so such a
    // write is dropped without any extra range check.
    always_comb begin
        wr_hit  = '0;
        at_term = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_hit[c]  = bus.wr_en && (bus.wr_ch == CH_W'(c));
            at_term[c] = (cnt_q[c] == active_q[c]);
        end
    end

    always_comb begin
        pend_d = pend_q;
        out_d  = out_q;
        tick_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c]    = cnt_q[c];
            active_d[c] = active_q[c];
            shadow_d[c] = shadow_q[c];

            if (!bus.en[c]) begin
                // Idle: hold the output low and the counter at zero. There is
                // no phase to protect, so writes land in active immediately
                // and any parked value is promoted.
                cnt_d[c] = '0;
                out_d[c] = 1'b0;
                if (wr_hit[c]) begin
                    active_d[c] = bus.wr_data;
                    shadow_d[c] = bus.wr_data;
                    pend_d[c]   = 1'b0;
                end else if (pend_q[c]) begin
                    active_d[c] = shadow_q[c];
                    pend_d[c]   = 1'b0;
                end
            end else if (at_term[c]) begin
                // Terminal count: toggle and start the next half-period. A
                // write on this very edge governs that next half-period, so it
                // bypasses the shadow instead of waiting a whole extra phase.
                cnt_d[c]  = '0;
                out_d[c]  = ~out_q[c];
                tick_d[c] = 1'b1;
                if (wr_hit[c]) begin
                    active_d[c] = bus.wr_data;
                    shadow_d[c] = bus.wr_data;
                    pend_d[c]   = 1'b0;
                end else if (pend_q[c]) begin
                    active_d[c] = shadow_q[c];
                    pend_d[c]   = 1'b0;
                end
            end else begin
                // Counting: cnt < active here, so the increment cannot wrap.
                // A write is parked; a later write before the terminal simply
                // overwrites the shadow.
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
                if (wr_hit[c]) begin
                    shadow_d[c] = bus.wr_data;
                    pend_d[c]   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c]    <= '0;
                active_q[c] <= '0;
                shadow_q[c] <= '0;
            end
            pend_q <= '0;
            out_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c]    <= cnt_d[c];
                active_q[c] <= active_d[c];
                shadow_q[c] <= shadow_d[c];
            end
            pend_q <= pend_d;
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.tick    = tick_q;
    assign bus.pending = pend_q;

    // active only changes on edges that also clear cnt, so the counter can
    // never overtake the divider value it is compared against.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chk
        a_cnt_bound: assert property (
            @(posedge clk) disable iff (!rst_n) cnt_q[g] <= active_q[g]
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - self-checking bench for clk_div_bank
module tb_clk_div_bank;
    localparam int CH  = 4;
    localparam int CW  = 8;
    localparam int CHW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clk_div_bank_if #(.CHANNELS(CH), .CNT_W(CW), .CH_W(CHW)) bus ();

    clk_div_bank #(.CHANNELS(CH), .CNT_W(CW), .CH_W(CHW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: per channel, the half-period length in force, an
    // optional queued length, and the number of enabled edges elapsed in the
    // current half-period.
    int           m_len  [CH];
    int           m_next [CH];
    int           m_run  [CH];
    bit [CH-1:0]  m_out;
    bit [CH-1:0]  m_tick;

    typedef struct {
        logic [CH-1:0]  en;
        logic           we;
        logic [CHW-1:0] wc;
        logic [CW-1:0]  wd;
        logic [CH-1:0]  exp_out;
        logic [CH-1:0]  exp_tick;
        logic [CH-1:0]  exp_pend;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [CH-1:0] m_pend();
        bit [CH-1:0] p;
        for (int c = 0; c < CH; c++) p[c] = (m_next[c] >= 0);
        return p;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_len[c]  = 0;
            m_next[c] = -1;
            m_run[c]  = 0;
        end
        m_out  = '0;
        m_tick = '0;
    endtask

    task automatic model_update();
        for (int c = 0; c < CH; c++) begin
            bit hit;
            hit = bus.wr_en && (int'(bus.wr_ch) == c);
            if (!bus.en[c]) begin
                m_run[c]  = 0;
                m_out[c]  = 1'b0;
                m_tick[c] = 1'b0;
                if (hit) begin
                    m_len[c]  = int'(bus.wr_data);
                    m_next[c] = -1;
                end else if (m_next[c] >= 0) begin
                    m_len[c]  = m_next[c];
                    m_next[c] = -1;
                end
            end else begin
                m_run[c]++;
                if (m_run[c] == m_len[c] + 1) begin
                    m_out[c]  = ~m_out[c];
                    m_tick[c] = 1'b1;
                    m_run[c]  = 0;
                    if (hit) begin
                        m_len[c]  = int'(bus.wr_data);
                        m_next[c] = -1;
                    end else if (m_next[c] >= 0) begin
                        m_len[c]  = m_next[c];
                        m_next[c] = -1;
                    end
                end else begin
                    m_tick[c] = 1'b0;
                    if (hit) m_next[c] = int'(bus.wr_data);
                end
            end
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare at negedge.
    task automatic cyc(input logic [CH-1:0] e, input logic we,
                       input logic [CHW-1:0] wc, input logic [CW-1:0] wd);
        bus.en      = e;
        bus.wr_en   = we;
        bus.wr_ch   = wc;
        bus.wr_data = wd;
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("model_out", bus.out, m_out);
        chk("model_tick", bus.tick, m_tick);
        chk("model_pending", bus.pending, m_pend());
        bus.wr_en = 1'b0;
    endtask

    vec_t vecs [7];

    initial begin
        bus.en = '0;
        bus.wr_en = 1'b0;
        bus.wr_ch = '0;
        bus.wr_data = '0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out", bus.out, 0);
        chk("reset_tick", bus.tick, 0);
        chk("reset_pending", bus.pending, 0);
        rst_n = 1'b1;

        // Divide-by-2 after reset, out-of-range writes, idle.
        vecs[0] = '{4'b0001, 1'b0, 3'd0, 8'd0, 4'b0001, 4'b0001, 4'b0000};
        vecs[1] = '{4'b0001, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b0001, 4'b0000};
        vecs[2] = '{4'b0001, 1'b0, 3'd0, 8'd0, 4'b0001, 4'b0001, 4'b0000};
        vecs[3] = '{4'b0001, 1'b1, 3'd5, 8'd9, 4'b0000, 4'b0001, 4'b0000};
        vecs[4] = '{4'b0001, 1'b0, 3'd0, 8'd0, 4'b0001, 4'b0001, 4'b0000};
        vecs[5] = '{4'b0001, 1'b1, 3'd4, 8'd3, 4'b0000, 4'b0001, 4'b0000};
        vecs[6] = '{4'b0000, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            cyc(vecs[i].en, vecs[i].we, vecs[i].wc, vecs[i].wd);
            chk($sformatf("vec%0d_out", i), bus.out, vecs[i].exp_out);
            chk($sformatf("vec%0d_tick", i), bus.tick, vecs[i].exp_tick);
            chk($sformatf("vec%0d_pend", i), bus.pending, vecs[i].exp_pend);
        end

        // Channel 1: idle write N=3, then run: 4 high / 4 low.
        cyc(4'b0000, 1'b1, 3'd1, 8'd3);
        chk("ch1_idle_write_pend", bus.pending[1], 0);
        for (int i = 0; i < 16; i++) begin
            cyc(4'b0010, 1'b0, 3'd0, 8'd0);
            chk($sformatf("ch1_out_%0d", i), bus.out[1], ((i + 1) / 4) % 2);
            chk($sformatf("ch1_tick_%0d", i), bus.tick[1], (i % 4 == 3));
            chk($sformatf("ch1_pend_%0d", i), bus.pending[1], 0);
        end
        cyc(4'b0000, 1'b0, 3'd0, 8'd0);

        // Channel 2: N=5, retune to N=1 when cnt=2.
        cyc(4'b0000, 1'b1, 3'd2, 8'd5);
        for (int i = 0; i < 6; i++) cyc(4'b0100, 1'b0, 3'd0, 8'd0);
        chk("ch2_first_rise", bus.out[2], 1);
        begin
            int t;
            t = 0;
            for (int j = 1; j <= 12; j++) begin
                cyc(4'b0100, (j == 3), 3'd2, 8'd1);
                if (j == 6 || j == 8 || j == 10 || j == 12) t++;
                chk($sformatf("ch2_out_%0d", j), bus.out[2], 1 ^ (t % 2));
                chk($sformatf("ch2_pend_%0d", j), bus.pending[2], (j >= 3 && j < 6));
            end
        end
        cyc(4'b0000, 1'b0, 3'd0, 8'd0);

        // Channel 0 at N=0: write N=7 on a terminal edge.
        cyc(4'b0001, 1'b0, 3'd0, 8'd0);
        cyc(4'b0001, 1'b0, 3'd0, 8'd0);
        cyc(4'b0001, 1'b1, 3'd0, 8'd7);
        chk("ch0_bypass_out", bus.out[0], 1);
        chk("ch0_bypass_pend", bus.pending[0], 0);
        for (int j = 1; j <= 8; j++) begin
            cyc(4'b0001, 1'b0, 3'd0, 8'd0);
            chk($sformatf("ch0_n7_out_%0d", j), bus.out[0], (j < 8) ? 1 : 0);
            chk($sformatf("ch0_n7_pend_%0d", j), bus.pending[0], 0);
        end

        // Two writes before the terminal (last wins), then an out-of-range one.
        begin
            int t;
            t = 0;
            for (int j = 1; j <= 14; j++) begin
                case (j)
                    1:       cyc(4'b0001, 1'b1, 3'd0, 8'd9);
                    2:       cyc(4'b0001, 1'b1, 3'd0, 8'd2);
                    3:       cyc(4'b0001, 1'b1, 3'd5, 8'd0);
                    default: cyc(4'b0001, 1'b0, 3'd0, 8'd0);
                endcase
                if (j == 8 || j == 11 || j == 14) t++;
                chk($sformatf("ch0_last_out_%0d", j), bus.out[0], t % 2);
                chk($sformatf("ch0_last_pend_%0d", j), bus.pending[0], (j >= 1 && j <= 7));
                if (j == 3) chk("oor_other_pend", bus.pending[3:1], 0);
            end
        end

        // Channel 3: drop en mid-half-period.
        cyc(4'b0001, 1'b1, 3'd3, 8'd3);
        for (int i = 0; i < 5; i++) cyc(4'b1001, 1'b0, 3'd0, 8'd0);
        chk("ch3_running_high", bus.out[3], 1);
        cyc(4'b0001, 1'b0, 3'd0, 8'd0);
        chk("ch3_drop_out", bus.out[3], 0);
        chk("ch3_drop_tick", bus.tick[3], 0);

        // Asynchronous reset while channels run with a write pending.
        cyc(4'b1111, 1'b1, 3'd1, 8'd6);
        cyc(4'b1111, 1'b0, 3'd0, 8'd0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_out", bus.out, 0);
        chk("async_rst_tick", bus.tick, 0);
        chk("async_rst_pend", bus.pending, 0);
        @(posedge clk);
        @(negedge clk);
        chk("held_rst_out", bus.out, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(4'b1111, 1'b0, 3'd0, 8'd0);
            chk($sformatf("post_rst_out_%0d", i), bus.out, (i % 2 == 0) ? 4'b1111 : 4'b0000);
            chk($sformatf("post_rst_tick_%0d", i), bus.tick, 4'b1111);
        end

        // Randomized traffic against the model.
        begin
            logic [CH-1:0] en_r;
            en_r = 4'b1111;
            for (int i = 0; i < 800; i++) begin
                logic           we;
                logic [CHW-1:0] wc;
                logic [CW-1:0]  wd;
                for (int c = 0; c < CH; c++)
                    if ($urandom_range(0, 15) == 0) en_r[c] = ~en_r[c];
                we = ($urandom_range(0, 2) == 0);
                wc = CHW'($urandom_range(0, 5));
                if ($urandom_range(0, 19) == 0) wd = CW'($urandom_range(0, 255));
                else wd = CW'($urandom_range(0, 9));
                cyc(en_r, we, wc, wd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
